// File: rtl/kanagawa_sim_multi_channel_concurrency_pipeline.sv
// Round-robin arbiter feeding a stallable fixed-latency delay line, with global and per-channel in-flight caps.
// Optional statistics counters are enabled by defining KANAGAWA_SIM_MCP_STATS_EN.
module kanagawa_sim_multi_channel_concurrency_pipeline #(
    parameter int NUM_CHANNELS    = 4,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_CONCURRENCY = 8,
    parameter int MAX_PER_CHANNEL = 0,
    parameter int LATENCY         = 8,
    localparam int CHAN_W         = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_CHANNELS-1:0]          valid_in,
    input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] data_in,
    output logic [NUM_CHANNELS-1:0]          ready_out,
    output logic                             valid_out,
    output logic [DATA_WIDTH-1:0]            data_out,
    output logic [CHAN_W-1:0]                chan_out,
    input  logic                             ready_in,
    input  logic                             ack_in,
    input  logic [CHAN_W-1:0]                ack_chan_in,
    output logic [31:0]                      stat_accepted_out,
    output logic [31:0]                      stat_cap_stall_out
);

    localparam int CAP_MAX = (MAX_CONCURRENCY > LATENCY) ? MAX_CONCURRENCY : LATENCY;
    localparam int CNT_W   = $clog2(CAP_MAX + 1) + 1;
    localparam logic [CNT_W-1:0] GLOBAL_CAP = CNT_W'(MAX_CONCURRENCY);
    localparam logic [CNT_W-1:0] CHAN_CAP   = CNT_W'(MAX_PER_CHANNEL);

    if (NUM_CHANNELS < 1) begin : g_err_chan
        $error("NUM_CHANNELS must be >= 1");
    end
    if (LATENCY < 1) begin : g_err_lat
        $error("LATENCY must be >= 1");
    end
    if (MAX_CONCURRENCY != 0 && LATENCY < MAX_CONCURRENCY) begin : g_err_cap
        $error("LATENCY must be >= MAX_CONCURRENCY");
    end

    logic [CHAN_W-1:0]       rr_q, rr_d;
    logic [CNT_W-1:0]        total_q, total_d;
    logic [CNT_W-1:0]        cnt_q [NUM_CHANNELS];
    logic [CNT_W-1:0]        cnt_d [NUM_CHANNELS];
    logic [LATENCY-1:0]      vld_q, vld_d;
    logic [CHAN_W-1:0]       chan_q [LATENCY];
    logic [CHAN_W-1:0]       chan_d [LATENCY];
    logic [DATA_WIDTH-1:0]   data_q [LATENCY];
    logic [DATA_WIDTH-1:0]   data_d [LATENCY];
    logic [NUM_CHANNELS-1:0] eligible, grant;
    logic [CHAN_W-1:0]       grant_idx, ack_idx;
    logic                    global_ok, ack_ok, ack_bad, accept;

    always_comb begin
        global_ok = (MAX_CONCURRENCY == 0) || (total_q < GLOBAL_CAP);
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            eligible[i] = valid_in[i] & ready_in & ~rst & global_ok &
                          ((MAX_PER_CHANNEL == 0) || (cnt_q[i] < CHAN_CAP));
        end
        // Walk downward so the channel closest to rr_q is the last, winning, assignment.
        grant     = '0;
        grant_idx = '0;
        for (int k = NUM_CHANNELS - 1; k >= 0; k--) begin
            if (eligible[(int'(rr_q) + k) % NUM_CHANNELS]) begin
                grant     = '0;
                grant[(int'(rr_q) + k) % NUM_CHANNELS] = 1'b1;
                grant_idx = CHAN_W'((int'(rr_q) + k) % NUM_CHANNELS);
            end
        end
        accept = |grant;
    end

    always_comb begin
        ack_idx = (int'(ack_chan_in) < NUM_CHANNELS) ? ack_chan_in : '0;
        ack_ok  = ack_in & ~rst & (int'(ack_chan_in) < NUM_CHANNELS) && (cnt_q[ack_idx] != '0);
        ack_bad = ack_in & ~rst & ~ack_ok;

        total_d = total_q;
        if (accept && !ack_ok) begin
            total_d = total_q + CNT_W'(1);
        end else if (!accept && ack_ok && total_q != '0) begin
            total_d = total_q - CNT_W'(1);
        end

        for (int i = 0; i < NUM_CHANNELS; i++) begin
            cnt_d[i] = cnt_q[i];
            if (grant[i] && !(ack_ok && int'(ack_idx) == i)) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end else if (!grant[i] && ack_ok && int'(ack_idx) == i) begin
                cnt_d[i] = cnt_q[i] - CNT_W'(1);
            end
        end

        rr_d = rr_q;
        if (accept) begin
            rr_d = (int'(grant_idx) == NUM_CHANNELS - 1) ? '0 : grant_idx + CHAN_W'(1);
        end
    end

    // The whole line, output stage included, holds while the consumer is not ready.
    always_comb begin
        vld_d  = vld_q;
        chan_d = chan_q;
        data_d = data_q;
        if (ready_in) begin
            for (int s = LATENCY - 1; s >= 1; s--) begin
                vld_d[s]  = vld_q[s-1];
                chan_d[s] = chan_q[s-1];
                data_d[s] = data_q[s-1];
            end
            vld_d[0]  = accept;
            chan_d[0] = grant_idx;
            data_d[0] = data_in[grant_idx*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q    <= '0;
            total_q <= '0;
            vld_q   <= '0;
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            rr_q    <= rr_d;
            total_q <= total_d;
            vld_q   <= vld_d;
            cnt_q   <= cnt_d;
        end
        chan_q <= chan_d;
        data_q <= data_d;
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (ack_bad) begin
            $error("%m underflow");
        end
    end
`endif

    assign ready_out = grant;
    assign valid_out = vld_q[LATENCY-1] & ~rst;
    assign data_out  = data_q[LATENCY-1];
    assign chan_out  = chan_q[LATENCY-1];

`ifdef KANAGAWA_SIM_MCP_STATS_EN
    logic [31:0]      stat_acc_q, stat_acc_d, stat_stall_q, stat_stall_d;
    logic [CNT_W-1:0] peak_q, peak_d;

    always_comb begin
        stat_acc_d   = stat_acc_q + (accept ? 32'd1 : 32'd0);
        stat_stall_d = stat_stall_q + ((ready_in && |valid_in && !accept) ? 32'd1 : 32'd0);
        peak_d       = (total_d > peak_q) ? total_d : peak_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_acc_q   <= '0;
            stat_stall_q <= '0;
            peak_q       <= '0;
        end else begin
            stat_acc_q   <= stat_acc_d;
            stat_stall_q <= stat_stall_d;
            peak_q       <= peak_d;
        end
    end

    final $display("%m accepted=%0d cap_stalls=%0d peak_total=%0d", stat_acc_q, stat_stall_q, peak_q);

    assign stat_accepted_out  = stat_acc_q;
    assign stat_cap_stall_out = stat_stall_q;
`else
    assign stat_accepted_out  = 32'd0;
    assign stat_cap_stall_out = 32'd0;
`endif

endmodule

// File: tb/tb_kanagawa_sim_multi_channel_concurrency_pipeline.sv
// Scoreboard bench: instance A (default caps) checks arbitration, latency, stalls and reset;
// instance B (per-channel cap 1) checks cap blocking and the stall statistic.
module tb_kanagawa_sim_multi_channel_concurrency_pipeline;
    localparam int N    = 4;
    localparam int DW   = 32;
    localparam int LAT  = 8;
    localparam int A_MC = 8;
    localparam int CW   = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          a_rst, a_ready_in, a_ack, a_valid_out;
    logic [N-1:0]  a_valid, a_ready_out;
    logic [N*DW-1:0] a_data;
    logic [DW-1:0] a_data_out;
    logic [CW-1:0] a_chan_out, a_ack_chan;
    logic [31:0]   a_stat_acc, a_stat_stall;

    logic          b_rst, b_ready_in, b_ack, b_valid_out;
    logic [N-1:0]  b_valid, b_ready_out;
    logic [N*DW-1:0] b_data;
    logic [DW-1:0] b_data_out;
    logic [CW-1:0] b_chan_out, b_ack_chan;
    logic [31:0]   b_stat_acc, b_stat_stall;

    kanagawa_sim_multi_channel_concurrency_pipeline #(
        .NUM_CHANNELS(N), .DATA_WIDTH(DW), .MAX_CONCURRENCY(A_MC), .MAX_PER_CHANNEL(0), .LATENCY(LAT)
    ) dut_a (
        .clk(clk), .rst(a_rst), .valid_in(a_valid), .data_in(a_data), .ready_out(a_ready_out),
        .valid_out(a_valid_out), .data_out(a_data_out), .chan_out(a_chan_out), .ready_in(a_ready_in),
        .ack_in(a_ack), .ack_chan_in(a_ack_chan), .stat_accepted_out(a_stat_acc),
        .stat_cap_stall_out(a_stat_stall)
    );

    kanagawa_sim_multi_channel_concurrency_pipeline #(
        .NUM_CHANNELS(N), .DATA_WIDTH(DW), .MAX_CONCURRENCY(8), .MAX_PER_CHANNEL(1), .LATENCY(LAT)
    ) dut_b (
        .clk(clk), .rst(b_rst), .valid_in(b_valid), .data_in(b_data), .ready_out(b_ready_out),
        .valid_out(b_valid_out), .data_out(b_data_out), .chan_out(b_chan_out), .ready_in(b_ready_in),
        .ack_in(b_ack), .ack_chan_in(b_ack_chan), .stat_accepted_out(b_stat_acc),
        .stat_cap_stall_out(b_stat_stall)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [CW-1:0] chan;
        logic [DW-1:0] data;
        int            en;
    } item_t;

    item_t sb[$];
    int    a_en = 0;
    int    cyc = 0;
    int    m_rr = 0;
    int    m_total = 0;
    int    m_cnt [N] = '{default: 0};
    bit    auto_ack = 1'b0;
    logic [N-1:0]  a_seen;
    logic          a_seen_valid;
    logic [CW-1:0] a_seen_chan;

    // One instance-A cycle: entered at a negedge with inputs set by the caller.
    task automatic cycle_a();
        int gi;
        logic [N-1:0] g;
        for (int ch = 0; ch < N; ch++) begin
            a_data[ch*DW +: DW] = 32'h1000_0000 * (ch + 1) + 32'(cyc);
        end
        if (auto_ack) begin
            a_ack      = a_valid_out & a_ready_in;
            a_ack_chan = a_chan_out;
        end
        #1;
        a_seen       = a_ready_out;
        a_seen_valid = a_valid_out;
        a_seen_chan  = a_chan_out;
        gi = -1;
        if (a_rst) begin
            check("a_rst_ready_out", a_ready_out, 0);
            check("a_rst_valid_out", a_valid_out, 0);
        end else begin
            if (a_ready_in && m_total < A_MC) begin
                for (int k = N - 1; k >= 0; k--) begin
                    if (a_valid[(m_rr + k) % N]) gi = (m_rr + k) % N;
                end
            end
            g = (gi >= 0) ? N'(1 << gi) : '0;
            check("a_grant", a_ready_out, g);
            if (gi >= 0) sb.push_back('{chan: CW'(gi), data: a_data[gi*DW +: DW], en: a_en});
        end
        @(posedge clk);
        if (a_rst) begin
            m_rr = 0;
            m_total = 0;
            m_cnt = '{default: 0};
            sb.delete();
        end else begin
            if (a_ready_in) a_en++;
            if (gi >= 0) begin
                m_total++;
                m_cnt[gi]++;
                m_rr = (gi + 1) % N;
            end
            if (a_ack && m_cnt[a_ack_chan] > 0) begin
                m_total--;
                m_cnt[a_ack_chan]--;
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (a_valid_out) begin
                if (sb.size() == 0) begin
                    check("a_unexpected_valid_out", a_valid_out, 0);
                end else begin
                    check("a_chan_out", a_chan_out, sb[0].chan);
                    check("a_data_out", a_data_out, sb[0].data);
                    if (a_ready_in) begin
                        check("a_latency", 64'(a_en - sb[0].en), LAT);
                        void'(sb.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    logic [N-1:0]  b_exp [10] = '{4'b0001, 4'b0010, 4'b0000, 4'b0000, 4'b0000,
                                 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0010};
    bit            b_ackv [10] = '{0, 0, 0, 0, 0, 0, 1, 0, 1, 0};
    logic [CW-1:0] b_ackc [10] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd0};
    logic [CW-1:0] rel_chan [3] = '{2'd1, 2'd3, 2'd0};

    initial begin
        int cnt;
        int first;
        a_rst = 1'b1; a_valid = '0; a_data = '0; a_ready_in = 1'b1; a_ack = 1'b0; a_ack_chan = '0;
        b_rst = 1'b1; b_valid = 4'b0011; b_data = '0; b_ready_in = 1'b1; b_ack = 1'b0; b_ack_chan = '0;
        @(negedge clk);

        // Instance B: per-channel cap of 1, no acks until vectors 6 and 8.
        for (int i = 0; i < 2; i++) begin
            #1;
            check("b_rst_ready_out", b_ready_out, 0);
            check("b_rst_valid_out", b_valid_out, 0);
            @(negedge clk);
        end
        b_rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            for (int ch = 0; ch < N; ch++) b_data[ch*DW +: DW] = 32'hB000_0000 + 32'(i * 16 + ch);
            b_ack      = b_ackv[i];
            b_ack_chan = b_ackc[i];
            #1;
            check("b_grant_vec", b_ready_out, b_exp[i]);
            @(negedge clk);
        end
        b_ack = 1'b0;
`ifdef KANAGAWA_SIM_MCP_STATS_EN
        check("b_stat_accepted", b_stat_acc, 4);
        check("b_stat_cap_stall", b_stat_stall, 6);
`else
        check("b_stat_accepted", b_stat_acc, 0);
        check("b_stat_cap_stall", b_stat_stall, 0);
`endif

        // Reset with requests pending.
        a_valid = 4'b1111;
        repeat (2) cycle_a();
        a_rst = 1'b0;

        // Rotation with auto-ack on output.
        auto_ack = 1'b1;
        first = -1;
        for (int i = 0; i < 20; i++) begin
            cycle_a();
            if (i < 4) check("a_rot_grant", a_seen, 64'(1 << i));
            if (first < 0 && a_seen_valid) first = i;
        end
        check("a_first_valid_cycle", 64'(first), 8);
        a_valid = '0;
        repeat (12) cycle_a();
        auto_ack = 1'b0;
        a_ack = 1'b0;

        // Accept and ack on ch2 in the same cycle.
        a_valid = 4'b0100;
        cycle_a();
        a_ack = 1'b1; a_ack_chan = 2'd2;
        cycle_a();
        a_ack = 1'b0;

        // Global cap: one item outstanding, so ch0 streaming gets seven more.
        a_valid = 4'b0001;
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            cycle_a();
            if (|a_seen) cnt++;
        end
        check("a_cap_accepts", 64'(cnt), 7);

        a_ack = 1'b1; a_ack_chan = 2'd0;
        cycle_a();
        check("a_ack_cycle_grant", a_seen, 0);
        a_ack = 1'b0;
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            cycle_a();
            if (i == 0) check("a_reopen_grant", a_seen, 4'b0001);
            if (|a_seen) cnt++;
        end
        check("a_reopen_accepts", 64'(cnt), 1);

        a_valid = '0;
        a_ack = 1'b1; a_ack_chan = 2'd2;
        cycle_a();
        a_ack_chan = 2'd0;
        repeat (7) cycle_a();
        a_ack = 1'b0;

        // Three items, then stall with the first one at the output.
        a_valid = 4'b0010; cycle_a();
        a_valid = 4'b1000; cycle_a();
        a_valid = 4'b0001; cycle_a();
        a_valid = '0;
        repeat (5) cycle_a();
        a_ready_in = 1'b0;
        a_valid = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            cycle_a();
            check("a_stall_no_grant", a_seen, 0);
            check("a_stall_valid_out", a_seen_valid, 1);
            check("a_stall_chan_out", a_seen_chan, 1);
        end
        a_ready_in = 1'b1;
        a_valid = '0;
        for (int i = 0; i < 3; i++) begin
            cycle_a();
            check("a_release_valid", a_seen_valid, 1);
            check("a_release_chan", a_seen_chan, rel_chan[i]);
        end

        // Reset with six in flight.
        a_valid = 4'b1111;
        repeat (3) cycle_a();
        a_rst = 1'b1;
        cycle_a();
        a_rst = 1'b0;
        cycle_a();
        check("a_post_rst_grant", a_seen, 4'b0001);
        check("a_post_rst_valid_out", a_seen_valid, 0);
        a_valid = 4'b0001;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            cycle_a();
            if (|a_seen) cnt++;
        end
        check("a_post_rst_accepts", 64'(cnt), 7);

        a_valid = '0;
        repeat (10) cycle_a();
        check("a_sb_drained", 64'(sb.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
